// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard: forward selects and mult/div start codes.
// Also fixes the width of the mult/div busy counter.
package hazard_pkg;

   typedef enum logic [1:0] {
      FW_NONE = 2'b00,
      FW_MEM  = 2'b01,
      FW_WB   = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      MD_NONE = 2'b00,
      MD_MUL  = 2'b01,
      MD_DIV  = 2'b10
   } md_op_t;

   localparam int MD_CNT_W = 4;

endpackage

// File: rtl/hazard_scoreboard_md_busy_ctr.sv
// Mult/div busy tracker: a start loads the op latency, then the count runs down to zero.
// md_busy is registered and rises the cycle after a start; it never stalls anything itself.
module md_busy_ctr
   import hazard_pkg::*;
#(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] md_start,
   output logic       md_busy
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

   md_state_t             state;
   logic [MD_CNT_W-1:0]   cnt;
   logic [MD_CNT_W-1:0]   cnt_nxt;

   // A start always wins, so it reloads a running op or one finishing this cycle.
   always_comb begin
      cnt_nxt = '0;
      if (md_start == MD_MUL) begin
         cnt_nxt = MD_CNT_W'(MUL_LAT);
      end else if (md_start == MD_DIV) begin
         cnt_nxt = MD_CNT_W'(DIV_LAT);
      end else if (cnt != '0) begin
         cnt_nxt = cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         state <= IDLE;
      end else begin
         cnt   <= cnt_nxt;
         state <= (cnt_nxt != '0) ? BUSY : IDLE;
      end
   end

   assign md_busy = (state == BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: combinational forwarding selects plus load-use, branch and mult/div stalls.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs_d,
   input  logic [REG_AW-1:0] rt_d,
   input  logic              use_rs_d,
   input  logic              use_rt_d,
   input  logic              branch_d,
   input  logic              likely_d,
   input  logic              taken_d,
   input  logic              md_use_d,
   input  logic [REG_AW-1:0] rs_e,
   input  logic [REG_AW-1:0] rt_e,
   input  logic [REG_AW-1:0] wa_e,
   input  logic              we_e,
   input  logic              load_e,
   input  logic [REG_AW-1:0] wa_m,
   input  logic              we_m,
   input  logic              load_m,
   input  logic [REG_AW-1:0] wa_w,
   input  logic              we_w,
   input  logic [1:0]        md_start_e,
   output logic [1:0]        fwd_a_d,
   output logic [1:0]        fwd_b_d,
   output logic [1:0]        fwd_a_e,
   output logic [1:0]        fwd_b_e,
   output logic              stall_pc,
   output logic              stall_if_id,
   output logic              flush_id_ex,
   output logic              flush_if_id,
`ifdef HAZARD_PERF_EN
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_cycles,
`endif
   output logic              md_busy
);

   logic load_use_stall;
   logic branch_stall;
   logic md_stall;
   logic any_stall;

   function automatic logic [1:0] fwd(input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] wam, input logic wem,
                                      input logic [REG_AW-1:0] waw, input logic wew);
      if (src == '0)                    fwd = FW_NONE;
      else if (wem && (src == wam))     fwd = FW_MEM;
      else if (wew && (src == waw))     fwd = FW_WB;
      else                              fwd = FW_NONE;
   endfunction

   // A used, non-zero source matching a destination; r0 never creates a hazard.
   function automatic logic hit(input logic [REG_AW-1:0] src, input logic use_src,
                                input logic [REG_AW-1:0] dst);
      hit = use_src && (src != '0) && (src == dst);
   endfunction

   assign fwd_a_d = fwd(rs_d, wa_m, we_m, wa_w, we_w);
   assign fwd_b_d = fwd(rt_d, wa_m, we_m, wa_w, we_w);
   assign fwd_a_e = fwd(rs_e, wa_m, we_m, wa_w, we_w);
   assign fwd_b_e = fwd(rt_e, wa_m, we_m, wa_w, we_w);

   assign load_use_stall = load_e && we_e &&
                           (hit(rs_d, use_rs_d, wa_e) || hit(rt_d, use_rt_d, wa_e));

   // Branches compare in ID, so any EX result or a load still in MEM is too late to forward.
   assign branch_stall = branch_d &&
                         ((we_e && (hit(rs_d, use_rs_d, wa_e) || hit(rt_d, use_rt_d, wa_e))) ||
                          (load_m && we_m &&
                           (hit(rs_d, use_rs_d, wa_m) || hit(rt_d, use_rt_d, wa_m))));

   assign md_stall = md_use_d &&
                     (md_busy || (md_start_e == MD_MUL) || (md_start_e == MD_DIV));

   assign any_stall   = load_use_stall || branch_stall || md_stall;
   assign stall_pc    = any_stall;
   assign stall_if_id = any_stall;
   assign flush_id_ex = any_stall;
   assign flush_if_id = likely_d && !taken_d && !any_stall;

   md_busy_ctr #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_md_busy_ctr (
      .clk      (clk),
      .reset    (reset),
      .md_start (md_start_e),
      .md_busy  (md_busy)
   );

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         if (any_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
         if (flush_if_id && (flush_cycles != '1)) flush_cycles <= flush_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vectors queue their expected outputs, a monitor compares.
module tb_hazard_scoreboard;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
   logic          use_rs_d, use_rt_d, branch_d, likely_d, taken_d, md_use_d;
   logic          we_e, load_e, we_m, load_m, we_w;
   logic [1:0]    md_start_e;
   logic [1:0]    fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
   logic          stall_pc, stall_if_id, flush_id_ex, flush_if_id, md_busy;
`ifdef HAZARD_PERF_EN
   logic [31:0]   stall_cycles, flush_cycles;
`endif

   always #5 clk = ~clk;

   hazard_scoreboard #(.REG_AW(AW), .MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset),
      .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
      .branch_d(branch_d), .likely_d(likely_d), .taken_d(taken_d), .md_use_d(md_use_d),
      .rs_e(rs_e), .rt_e(rt_e), .wa_e(wa_e), .we_e(we_e), .load_e(load_e),
      .wa_m(wa_m), .we_m(we_m), .load_m(load_m), .wa_w(wa_w), .we_w(we_w),
      .md_start_e(md_start_e),
      .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
      .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_id_ex(flush_id_ex),
      .flush_if_id(flush_if_id),
`ifdef HAZARD_PERF_EN
      .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
      .md_busy(md_busy)
   );

   typedef struct {
      string       name;
      logic [7:0]  fwd;      // {fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e}
      logic        stall;
      logic        flush;
      logic        busy;
      logic        chk_perf;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every cycle that has a queued expectation, sample mid-cycle and compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.name, ".fwd"}, 32'({fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e}), 32'(e.fwd));
            cmp({e.name, ".stall"}, 32'({stall_pc, stall_if_id, flush_id_ex}),
                32'({3{e.stall}}));
            cmp({e.name, ".flush_if_id"}, 32'(flush_if_id), 32'(e.flush));
            cmp({e.name, ".md_busy"}, 32'(md_busy), 32'(e.busy));
`ifdef HAZARD_PERF_EN
            if (e.chk_perf) begin
               cmp({e.name, ".stall_cycles"}, stall_cycles, e.sc);
               cmp({e.name, ".flush_cycles"}, flush_cycles, e.fc);
            end
`endif
         end
      end
   end

   task automatic clr();
      reset = 1'b0;
      {rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w} = '0;
      {use_rs_d, use_rt_d, branch_d, likely_d, taken_d, md_use_d} = '0;
      {we_e, load_e, we_m, load_m, we_w} = '0;
      md_start_e = 2'b00;
   endtask

   // Inputs are already applied; queue the expectation and hold them for one cycle.
   task automatic vec(input string name, input logic [7:0] fwd, input logic st,
                      input logic fl, input logic bz, input logic cp = 1'b0,
                      input logic [31:0] sc = 32'd0, input logic [31:0] fc = 32'd0);
      exp_t e;
      e.name = name; e.fwd = fwd; e.stall = st; e.flush = fl; e.busy = bz;
      e.chk_perf = cp; e.sc = sc; e.fc = fc;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      reset = 1'b1;
      @(posedge clk); #1;
      vec("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);

      // Forwarding priority MEM over WB, r0 never forwarded
      clr(); wa_m = 8; we_m = 1; wa_w = 8; we_w = 1; rs_e = 8;
      vec("fwd_mem", 8'b00_00_01_00, 0, 0, 0);
      we_m = 0;
      vec("fwd_wb", 8'b00_00_10_00, 0, 0, 0);
      rs_e = 0;
      vec("fwd_r0", 8'b00_00_00_00, 0, 0, 0);
      rs_d = 8; rt_e = 8;
      vec("fwd_wb_d_b", 8'b10_00_00_10, 0, 0, 0);

      // Load-use: one stall, then the load is in MEM and forwards
      clr(); load_e = 1; we_e = 1; wa_e = 9; rt_d = 9; use_rt_d = 1;
      vec("ld_use", 8'h00, 1, 0, 0);
      load_e = 0; we_e = 0; wa_e = 0; load_m = 1; we_m = 1; wa_m = 9; rt_e = 9;
      vec("ld_use_adv", 8'b00_01_00_01, 0, 0, 0);
      clr(); load_e = 1; we_e = 1; wa_e = 9; rt_d = 9; use_rt_d = 0;
      vec("ld_nouse", 8'h00, 0, 0, 0);
      clr(); load_e = 1; we_e = 1; wa_e = 0; rt_d = 0; use_rt_d = 1;
      vec("ld_r0", 8'h00, 0, 0, 0);

      // Branch operand hazards
      clr(); branch_d = 1; rs_d = 4; use_rs_d = 1; wa_m = 4; load_m = 1; we_m = 1;
      vec("br_ld_mem", 8'b01_00_00_00, 1, 0, 0);
      load_m = 0;
      vec("br_alu_mem", 8'b01_00_00_00, 0, 0, 0);
      clr(); branch_d = 1; rt_d = 6; use_rt_d = 1; we_e = 1; wa_e = 6;
      vec("br_ex", 8'h00, 1, 0, 0);

      // Branch-likely not taken flushes IF/ID, but never during a stall
      clr(); likely_d = 1; taken_d = 0;
      vec("likely_nt", 8'h00, 0, 1, 0);
      taken_d = 1;
      vec("likely_t", 8'h00, 0, 0, 0);
      taken_d = 0; load_e = 1; we_e = 1; wa_e = 9; rt_d = 9; use_rt_d = 1;
      vec("likely_stall", 8'h00, 1, 0, 0);

      // Multiply: start cycle stalls, 5 busy cycles, released after
      clr(); md_use_d = 1; md_start_e = 2'b01;
      vec("mul_start", 8'h00, 1, 0, 0);
      md_start_e = 2'b00;
      for (int i = 0; i < 5; i++) vec("mul_busy", 8'h00, 1, 0, 1);
      vec("mul_done", 8'h00, 0, 0, 0);

      // Divide: 10 busy cycles
      md_start_e = 2'b10;
      vec("div_start", 8'h00, 1, 0, 0);
      md_start_e = 2'b00;
      for (int i = 0; i < 10; i++) vec("div_busy", 8'h00, 1, 0, 1);
      vec("div_done", 8'h00, 0, 0, 0);

      // Reserved start code behaves as none
      md_start_e = 2'b11;
      vec("md_rsvd", 8'h00, 0, 0, 0);
      md_start_e = 2'b00;
      vec("md_rsvd_idle", 8'h00, 0, 0, 0);

      // Restart while busy reloads the counter
      md_use_d = 0; md_start_e = 2'b01;
      vec("re_mul", 8'h00, 0, 0, 0);
      md_start_e = 2'b10;
      vec("re_div", 8'h00, 0, 0, 1);
      md_start_e = 2'b00;
      for (int i = 0; i < 10; i++) vec("re_busy", 8'h00, 0, 0, 1);
      vec("re_done", 8'h00, 0, 0, 0);

      // Reset with counter at 3 abandons the op
      md_start_e = 2'b01;
      vec("rst_mul", 8'h00, 0, 0, 0);
      md_start_e = 2'b00;
      vec("rst_c5", 8'h00, 0, 0, 1);
      vec("rst_c4", 8'h00, 0, 0, 1);
      reset = 1;
      vec("rst_c3", 8'h00, 0, 0, 1);
      reset = 0; md_use_d = 1;
      vec("rst_after", 8'h00, 0, 0, 0, 1'b1, 32'd0, 32'd0);

      // Perf counters restart from zero after reset
      md_start_e = 2'b01;
      vec("perf_s0", 8'h00, 1, 0, 0, 1'b1, 32'd0, 32'd0);
      md_start_e = 2'b00; md_use_d = 0; likely_d = 1;
      vec("perf_s1", 8'h00, 0, 1, 1, 1'b1, 32'd1, 32'd0);
      likely_d = 0;
      vec("perf_s2", 8'h00, 0, 0, 1, 1'b1, 32'd1, 32'd1);

      // Drain with a bounded wait
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
